// File: rtl/main_control_fsm_pkg.sv
// rtl/main_control_fsm_pkg.sv - shared types and encodings for the multicycle main controller
// Purpose: state enum, opcode constants, datapath mux encodings, ALU decoder
//          class constants and the per-state control word layout.
// Ports:   none (package).
package main_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RS_ALUOUT    = 2'b00;
  localparam logic [1:0] RS_DATA      = 2'b01;
  localparam logic [1:0] RS_ALURESULT = 2'b10;

  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_RS1   = 2'b10;

  localparam logic [1:0] SB_RS2  = 2'b00;
  localparam logic [1:0] SB_IMM  = 2'b01;
  localparam logic [1:0] SB_FOUR = 2'b10;

  // ALU decoder class bit: ADD for address/PC arithmetic, funct3 for real ops.
  localparam logic ALUD_ADD    = 1'b0;
  localparam logic ALUD_FUNCT3 = 1'b1;

  // Raw per-state control word. The *_on_* fields are requests the top
  // qualifies with MemReady / Zero and reset before they reach the pins.
  typedef struct packed {
    logic       alud;
    logic       fxor;
    logic       pcw_always;
    logic       pcw_on_ready;
    logic       pcw_on_zero;
    logic       irw_on_ready;
    logic       adr_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
  } ctrl_t;

  // Opcode dispatch out of DECODE.
  function automatic state_t decode_op(input logic [6:0] op);
    case (op)
      OP_LW, OP_SW: decode_op = S_MEMADR;
      OP_R:         decode_op = S_EXECUTER;
      OP_I:         decode_op = S_EXECUTEI;
      OP_BEQ:       decode_op = S_BEQ;
      OP_JAL:       decode_op = S_JAL;
      default:      decode_op = S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/main_control_fsm_ctrl_output_rom.sv
// rtl/main_control_fsm_ctrl_output_rom.sv - pure state-to-control-word decode
// Purpose: Moore output table of the main controller; no qualification.
// Ports:   i_state - current FSM state
//          o_ctrl  - raw control word for that state
module main_control_fsm_ctrl_output_rom
  import main_control_fsm_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.adr_src      = 1'b0;
        o_ctrl.alu_src_a    = SA_PC;
        o_ctrl.alu_src_b    = SB_FOUR;
        o_ctrl.alud         = ALUD_ADD;
        o_ctrl.result_src   = RS_ALURESULT;
        o_ctrl.pcw_on_ready = 1'b1;
        o_ctrl.irw_on_ready = 1'b1;
      end
      S_DECODE: begin
        // Branch/jump target precomputed as OldPC + Imm.
        o_ctrl.alu_src_a = SA_OLDPC;
        o_ctrl.alu_src_b = SB_IMM;
        o_ctrl.alud      = ALUD_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = SA_RS1;
        o_ctrl.alu_src_b = SB_IMM;
        o_ctrl.alud      = ALUD_ADD;
      end
      S_MEMREAD: begin
        o_ctrl.adr_src    = 1'b1;
        o_ctrl.result_src = RS_ALUOUT;
      end
      S_MEMWB: begin
        o_ctrl.result_src = RS_DATA;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_ctrl.adr_src    = 1'b1;
        o_ctrl.result_src = RS_ALUOUT;
        o_ctrl.mem_write  = 1'b1;
      end
      S_EXECUTER: begin
        o_ctrl.alu_src_a = SA_RS1;
        o_ctrl.alu_src_b = SB_RS2;
        o_ctrl.alud      = ALUD_FUNCT3;
      end
      S_EXECUTEI: begin
        o_ctrl.alu_src_a = SA_RS1;
        o_ctrl.alu_src_b = SB_IMM;
        o_ctrl.alud      = ALUD_FUNCT3;
      end
      S_ALUWB: begin
        o_ctrl.result_src = RS_ALUOUT;
        o_ctrl.reg_write  = 1'b1;
      end
      S_JAL: begin
        // PC <= target held in ALUOut while the ALU forms OldPC + 4 for rd.
        o_ctrl.alu_src_a  = SA_OLDPC;
        o_ctrl.alu_src_b  = SB_FOUR;
        o_ctrl.alud       = ALUD_ADD;
        o_ctrl.result_src = RS_ALUOUT;
        o_ctrl.pcw_always = 1'b1;
      end
      S_BEQ: begin
        // XOR of rs1/rs2 gives Zero exactly when the operands are equal.
        o_ctrl.alu_src_a   = SA_RS1;
        o_ctrl.alu_src_b   = SB_RS2;
        o_ctrl.alud        = ALUD_FUNCT3;
        o_ctrl.fxor        = 1'b1;
        o_ctrl.result_src  = RS_ALUOUT;
        o_ctrl.pcw_on_zero = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle RISC-V main controller FSM
// Purpose: sequences lw/sw/R/I/beq/jal through fetch..writeback, drives the
//          datapath enables and muxes, feeds ALUD/FXor to the ALU decoder,
//          waits on MemReady and counts retired instructions.
// Ports:   clk, rst (sync, active high); op, Zero, MemReady inputs;
//          ALUD, FXor, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
//          ALUSrcA, ALUSrcB, RegWrite, Illegal, Instret outputs.
module main_control_fsm
  import main_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             ALUD,
  output logic             FXor,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             Illegal,
  output logic [CNT_W-1:0] Instret
);

  state_t           r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;
  ctrl_t            w_ctrl;

  main_control_fsm_ctrl_output_rom u_rom (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Write enables are gated by rst so an abandoned instruction never writes.
  assign PCWrite   = ~rst & (w_ctrl.pcw_always
                           | (w_ctrl.pcw_on_ready & MemReady)
                           | (w_ctrl.pcw_on_zero  & Zero));
  assign IRWrite   = ~rst & w_ctrl.irw_on_ready & MemReady;
  assign MemWrite  = ~rst & w_ctrl.mem_write;
  assign RegWrite  = ~rst & w_ctrl.reg_write;
  assign ALUD      = w_ctrl.alud;
  assign FXor      = w_ctrl.fxor;
  assign AdrSrc    = w_ctrl.adr_src;
  assign ResultSrc = w_ctrl.result_src;
  assign ALUSrcA   = w_ctrl.alu_src_a;
  assign ALUSrcB   = w_ctrl.alu_src_b;
  assign Illegal   = r_illegal;
  assign Instret   = r_instret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (MemReady) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_state <= decode_op(op);
          if (decode_op(op) == S_ILLEGAL) r_illegal <= 1'b1;
        end
        S_MEMADR: begin
          // Only lw/sw reach here, so a single compare picks the path.
          r_state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          if (MemReady) r_state <= S_MEMWB;
        end
        S_MEMWB: begin
          r_state   <= S_FETCH;
          r_instret <= r_instret + CNT_W'(1);
        end
        S_MEMWRITE: begin
          if (MemReady) begin
            r_state   <= S_FETCH;
            r_instret <= r_instret + CNT_W'(1);
          end
        end
        S_EXECUTER, S_EXECUTEI, S_JAL: begin
          r_state <= S_ALUWB;
        end
        S_ALUWB, S_BEQ: begin
          r_state   <= S_FETCH;
          r_instret <= r_instret + CNT_W'(1);
        end
        S_ILLEGAL: begin
          r_state <= S_ILLEGAL;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - directed self-checking bench for main_control_fsm
module tb_main_control_fsm;

  // Output word: {ALUD,FXor,PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,RegWrite,Illegal}
  localparam logic [14:0] E_FETCH    = 15'b0_0_1_0_0_1_10_00_10_0_0;
  localparam logic [14:0] E_FWAIT    = 15'b0_0_0_0_0_0_10_00_10_0_0;
  localparam logic [14:0] E_DECODE   = 15'b0_0_0_0_0_0_00_01_01_0_0;
  localparam logic [14:0] E_MEMADR   = 15'b0_0_0_0_0_0_00_10_01_0_0;
  localparam logic [14:0] E_MEMREAD  = 15'b0_0_0_1_0_0_00_00_00_0_0;
  localparam logic [14:0] E_MEMWB    = 15'b0_0_0_0_0_0_01_00_00_1_0;
  localparam logic [14:0] E_MEMWRITE = 15'b0_0_0_1_1_0_00_00_00_0_0;
  localparam logic [14:0] E_MW_RST   = 15'b0_0_0_1_0_0_00_00_00_0_0;
  localparam logic [14:0] E_EXECR    = 15'b1_0_0_0_0_0_00_10_00_0_0;
  localparam logic [14:0] E_EXECI    = 15'b1_0_0_0_0_0_00_10_01_0_0;
  localparam logic [14:0] E_ALUWB    = 15'b0_0_0_0_0_0_00_00_00_1_0;
  localparam logic [14:0] E_JAL      = 15'b0_0_1_0_0_0_00_01_10_0_0;
  localparam logic [14:0] E_BEQ_T    = 15'b1_1_1_0_0_0_00_10_00_0_0;
  localparam logic [14:0] E_BEQ_N    = 15'b1_1_0_0_0_0_00_10_00_0_0;
  localparam logic [14:0] E_ILL      = 15'b0_0_0_0_0_0_00_00_00_0_1;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst, Zero, MemReady;
  logic [6:0]  op;
  logic        ALUD, FXor, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [31:0] Instret;
  logic        ALUD4, FXor4, PCWrite4, AdrSrc4, MemWrite4, IRWrite4, RegWrite4, Illegal4;
  logic [1:0]  ResultSrc4, ALUSrcA4, ALUSrcB4;
  logic [3:0]  Instret4;
  logic [14:0] w_out, w_out4;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  main_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .Zero(Zero), .MemReady(MemReady),
    .ALUD(ALUD), .FXor(FXor), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .Illegal(Illegal), .Instret(Instret)
  );

  main_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .op(op), .Zero(Zero), .MemReady(MemReady),
    .ALUD(ALUD4), .FXor(FXor4), .PCWrite(PCWrite4), .AdrSrc(AdrSrc4),
    .MemWrite(MemWrite4), .IRWrite(IRWrite4), .ResultSrc(ResultSrc4),
    .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4), .RegWrite(RegWrite4),
    .Illegal(Illegal4), .Instret(Instret4)
  );

  assign w_out  = {ALUD, FXor, PCWrite, AdrSrc, MemWrite, IRWrite,
                   ResultSrc, ALUSrcA, ALUSrcB, RegWrite, Illegal};
  assign w_out4 = {ALUD4, FXor4, PCWrite4, AdrSrc4, MemWrite4, IRWrite4,
                   ResultSrc4, ALUSrcA4, ALUSrcB4, RegWrite4, Illegal4};

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [14:0] exp);
    tests++;
    assert (w_out === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, w_out, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    tests++;
    assert (Instret === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, Instret, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a junk opcode.
    rst = 1'b1; op = 7'b1010101; MemReady = 1'b1; Zero = 1'b0;
    nxt(); op = 7'b0110111; nxt(); #1;
    chk("rst_outs", E_FWAIT);
    chk_cnt("rst_cnt", 32'd0);

    // R-type, no waits.
    rst = 1'b0; op = T_R; #1;
    chk("r_fetch", E_FETCH);
    nxt(); chk("r_decode", E_DECODE);
    nxt(); chk("r_exec", E_EXECR);
    nxt(); chk("r_wb", E_ALUWB); chk_cnt("r_cnt_pre", 32'd0);
    nxt(); chk("r_done", E_FETCH); chk_cnt("r_cnt", 32'd1);

    // lw: one fetch wait, two MEMREAD waits.
    op = T_LW; MemReady = 1'b0; #1;
    chk("lw_fetch_wait", E_FWAIT);
    nxt(); chk("lw_fetch_wait_hold", E_FWAIT);
    MemReady = 1'b1; #1; chk("lw_fetch", E_FETCH);
    nxt(); chk("lw_decode", E_DECODE);
    nxt(); chk("lw_memadr", E_MEMADR);
    nxt(); MemReady = 1'b0; #1; chk("lw_memread0", E_MEMREAD);
    nxt(); chk("lw_memread1", E_MEMREAD);
    nxt(); MemReady = 1'b1; #1; chk("lw_memread2", E_MEMREAD);
    nxt(); chk("lw_memwb", E_MEMWB); chk_cnt("lw_cnt_pre", 32'd1);
    nxt(); chk("lw_done", E_FETCH); chk_cnt("lw_cnt", 32'd2);

    // beq taken then not taken.
    op = T_BEQ;
    nxt(); chk("beq_decode", E_DECODE);
    nxt(); Zero = 1'b1; #1; chk("beq_taken", E_BEQ_T);
    nxt(); Zero = 1'b0; #1; chk("beq_t_done", E_FETCH); chk_cnt("beq_t_cnt", 32'd3);
    nxt(); nxt(); chk("beq_not_taken", E_BEQ_N);
    nxt(); chk_cnt("beq_n_cnt", 32'd4);

    // jal.
    op = T_JAL;
    nxt(); chk("jal_decode", E_DECODE);
    nxt(); chk("jal_jal", E_JAL);
    nxt(); chk("jal_wb", E_ALUWB);
    nxt(); chk("jal_done", E_FETCH); chk_cnt("jal_cnt", 32'd5);

    // Unsupported opcode: absorbing ILLEGAL.
    op = 7'b1111111;
    nxt(); chk("ill_decode", E_DECODE);
    nxt();
    for (int i = 0; i < 10; i++) begin
      MemReady = i[0]; Zero = ~i[0]; #1;
      chk("ill_hold", E_ILL);
      nxt();
    end
    MemReady = 1'b1; Zero = 1'b0; rst = 1'b1;
    nxt(); chk("ill_rst", E_FWAIT); chk_cnt("ill_rst_cnt", 32'd0);

    // sw abandoned by reset while waiting in MEMWRITE.
    rst = 1'b0; op = T_SW; #1;
    chk("sw_fetch", E_FETCH);
    nxt(); chk("sw_decode", E_DECODE);
    nxt(); chk("sw_memadr", E_MEMADR);
    nxt(); MemReady = 1'b0; #1; chk("sw_memwrite0", E_MEMWRITE);
    nxt(); chk("sw_memwrite1", E_MEMWRITE);
    rst = 1'b1; MemReady = 1'b1; #1; chk("sw_rst_drop", E_MW_RST);
    nxt(); chk("sw_rst_fetch", E_FWAIT); chk_cnt("sw_rst_cnt", 32'd0);

    // 16 addi: 32-bit counter reaches 16, 4-bit counter wraps to 0.
    rst = 1'b0; op = T_I;
    for (int i = 0; i < 16; i++) begin
      nxt();
      nxt(); if (i == 0) chk("addi_exec", E_EXECI);
      nxt();
      if (i == 15) begin
        tests++;
        assert (Instret4 === 4'd15) else begin
          fails++;
          $error("FAIL wrap_pre: observed %0d expected 15", Instret4);
        end
      end
      nxt();
    end
    chk_cnt("addi_cnt32", 32'd16);
    tests++;
    assert (Instret4 === 4'd0) else begin
      fails++;
      $error("FAIL wrap_cnt4: observed %0d expected 0", Instret4);
    end
    tests++;
    assert (w_out4 === E_FETCH) else begin
      fails++;
      $error("FAIL wrap_outs4: observed %b expected %b", w_out4, E_FETCH);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
- Multicycle RISC-V main controller FSM, directly upstream of the ALU decoder.
- Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type, I-type ALU, beq and jal.
- Drives datapath enables and muxes, plus the 1-bit ALUD class bit and a funct3 override that feed the ALU decoder.
- Handles variable-latency memory via a ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  instruction opcode field, valid from DECODE onward.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- ALUD  out  1  to ALU decoder: 0 = force ADD, 1 = use funct3.
- FXor  out  1  forces the decoder's funct3 input to 3'b100 (XOR); used for beq compare.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction/OldPC register enable.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B mux: 00 = rs2, 01 = Imm, 10 = const 4.
- RegWrite  out  1  register file write enable.
- Illegal  out  1  sticky flag: unsupported opcode decoded.
- Instret  out  CNT_W  retired-instruction count.

Behaviour:
- Moore FSM with state register. All outputs decode combinationally from state, except that PCWrite, IRWrite and Instret updates are qualified as stated below.
- Unlisted outputs are 0 in each state.
- Reset:
  - While rst = 1, all write enables (PCWrite, MemWrite, IRWrite, RegWrite) are forced to 0.
  - At the clock edge: state <= FETCH, Illegal <= 0, Instret <= 0.
  - Reset mid-operation abandons the instruction with no writes.
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUD=0, ResultSrc=10.
  - IRWrite and PCWrite = MemReady.
  - Stay in FETCH while MemReady = 0; go to DECODE when MemReady = 1.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUD=0 (branch/jump target).
  - Next state by op:
    - 0000011 (lw) and 0100011 (sw) -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other -> ILLEGAL
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUD=0.
  - Next: lw -> MEMREAD, sw -> MEMWRITE. op is re-sampled here; the IR is stable.
- MEMREAD:
  - Outputs: AdrSrc=1, ResultSrc=00.
  - Hold until MemReady = 1, then go to MEMWB.
- MEMWB:
  - Outputs: ResultSrc=01, RegWrite=1.
  - Next: FETCH, retire.
- MEMWRITE:
  - Outputs: AdrSrc=1, ResultSrc=00, MemWrite=1, held while waiting.
  - When MemReady = 1: go to FETCH, retire.
- EXECUTER:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUD=1.
  - Next: ALUWB.
- EXECUTEI:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUD=1.
  - Next: ALUWB.
- ALUWB:
  - Outputs: ResultSrc=00, RegWrite=1.
  - Next: FETCH, retire.
- JAL:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUD=0, ResultSrc=00, PCWrite=1.
  - Next: ALUWB (writes PC+4 to rd).
- BEQ:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUD=1, FXor=1, ResultSrc=00.
  - PCWrite = Zero.
  - Next: FETCH, retire.
- ILLEGAL:
  - All enables 0, Illegal = 1.
  - Absorbing; only rst exits.
- Retire: Instret increments by 1 on each retiring transition and wraps modulo 2^CNT_W.
- Latency in cycles, with zero memory wait:
  - lw 5
  - sw 4
  - R/I-type 4
  - jal 4
  - beq 3
  - Each MemReady = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Decomposition:
- Shared package holds:
  - state enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ResultSrc / ALUSrcA / ALUSrcB encodings
  - the ALUD class constants, which are also consumed by the ALU decoder
- Optional sub-module ctrl_output_rom: pure state-to-output decode.
- Next-state logic and the counter stay in the top module.

Test Plan:
- rst=1 for 2 cycles with arbitrary op -> state FETCH, all enables 0, Instret=0, Illegal=0.
- R-type op=0110011, MemReady=1 -> FETCH, DECODE, EXECUTER (ALUD=1), ALUWB (RegWrite=1), FETCH; Instret=1.
- lw op=0000011 with MemReady low 2 cycles in MEMREAD -> MEMREAD held 3 cycles with AdrSrc=1, then MEMWB RegWrite=1; total 7 cycles.
- beq op=1100011: Zero=1 -> PCWrite=1 in BEQ with FXor=1, ALUD=1; repeat with Zero=0 -> PCWrite=0; Instret advances in both cases.
- op=1111111 -> ILLEGAL, Illegal=1 held for 10 cycles, no enables asserted; then rst -> FETCH, Illegal=0.
- sw with rst asserted in MEMWRITE -> MemWrite drops to 0 that cycle, state FETCH next, Instret unchanged; a CNT_W=4 run of 16 addi instructions wraps Instret to 0.
